// File: rtl/nano4k_flash_job_sequencer.sv
// nano4k_flash_job_sequencer: ready/valid job engine issuing WREN/op/RDSR-poll command chains to nano4k_spi_flash
module nano4k_flash_job_sequencer #(
  parameter int ADDR_WIDTH = 22,
  parameter int LEN_WIDTH = 9,
  parameter int PAGE_BYTES = 256,
  parameter int CMD_HOLD = 64,
  parameter int GAP_CYCLES = 16,
  parameter int POLL_GAP = 256,
  parameter int POLL_MAX = 65535,
  parameter logic [7:0] OP_WREN = 8'h06,
  parameter logic [7:0] OP_RDSR = 8'h05,
  parameter logic [7:0] OP_PP = 8'h02,
  parameter logic [7:0] OP_PE = 8'h81,
  parameter logic [7:0] OP_SE = 8'h20,
  parameter logic [7:0] OP_FREAD = 8'h0B,
  parameter logic [7:0] OP_RDID = 8'h9F
) (
  input  logic                  interfaceClk,
  input  logic                  reset,
  input  logic                  jobValid,
  output logic                  jobReady,
  input  logic [2:0]            jobOp,
  input  logic [ADDR_WIDTH-1:0] jobAddr,
  input  logic [LEN_WIDTH-1:0]  jobLen,
  input  logic [7:0]            wrData,
  output logic                  wrTake,
  output logic [7:0]            rdData,
  output logic                  rdValid,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  fEnable_n,
  output logic [7:0]            fCommand,
  output logic [ADDR_WIDTH-1:0] fAddress,
  output logic [7:0]            fData_WR,
  input  logic [7:0]            fData_RD,
  input  logic                  RdDataValid,
  input  logic                  WrDataReady
);
  localparam int PW = $clog2(PAGE_BYTES);
  localparam logic [3:0] S_IDLE = 4'd0, S_CHECK = 4'd1, S_WREN_ON = 4'd2, S_WREN_HOLD = 4'd3,
                         S_GAP_A = 4'd4, S_OP_ON = 4'd5, S_OP_DATA = 4'd6, S_OP_HOLD = 4'd7,
                         S_GAP_B = 4'd8, S_POLL_ON = 4'd9, S_POLL_WAIT = 4'd10, S_POLL_GAP = 4'd11,
                         S_FINISH = 4'd12;
  logic [3:0]            r_state;
  logic [2:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr, r_faddr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH:0]    r_cnt;
  logic [15:0]           r_timer, r_polls;
  logic [7:0]            r_cmd, r_rd_data;
  logic                  r_err, r_en_n, r_rd_valid, r_done, r_error;
  logic                  w_is_read, w_is_erase, w_illegal, w_ovf, w_strobe, w_tz;
  logic [7:0]            w_opcode;
  assign w_is_read  = (r_op == 3'd0) || (r_op == 3'd1) || (r_op == 3'd5);
  assign w_is_erase = (r_op == 3'd3) || (r_op == 3'd4);
  assign w_illegal  = r_op > 3'd5;
  assign w_ovf      = (r_op == 3'd2) && (32'(r_addr[PW-1:0]) + 32'(r_len) + 32'd1 > 32'(PAGE_BYTES));
  assign w_opcode   = r_op == 3'd0 ? OP_RDID : r_op == 3'd1 ? OP_FREAD : r_op == 3'd2 ? OP_PP :
                      r_op == 3'd3 ? OP_PE : r_op == 3'd4 ? OP_SE : OP_RDSR;
  assign w_strobe   = w_is_read ? RdDataValid : WrDataReady;
  assign w_tz       = r_timer == 16'd0;
  assign jobReady   = (r_state == S_IDLE) && !r_done;
  assign busy       = !jobReady;
  assign done       = r_done;
  assign error      = r_error;
  assign rdData     = r_rd_data;
  assign rdValid    = r_rd_valid;
  assign wrTake     = (r_state == S_OP_DATA) && (r_op == 3'd2) && WrDataReady;
  assign fEnable_n  = r_en_n;
  assign fCommand   = r_cmd;
  assign fAddress   = r_faddr;
  assign fData_WR   = wrData;
  // job sequencing FSM: command windows, gaps, byte counting and status polling
  always_ff @(posedge interfaceClk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_timer <= '0;
      r_polls <= '0;
      r_cmd <= '0;
      r_faddr <= '0;
      r_rd_data <= '0;
      r_err <= 1'b0;
      r_en_n <= 1'b1;
      r_rd_valid <= 1'b0;
      r_done <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: if (jobValid && jobReady) begin
          r_op <= jobOp;
          r_addr <= jobAddr;
          r_len <= jobLen;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_err <= w_illegal || w_ovf;
          r_polls <= '0;
          r_state <= (w_illegal || w_ovf) ? S_FINISH : w_is_read ? S_OP_ON : S_WREN_ON;
        end
        S_WREN_ON: begin
          r_en_n <= 1'b0;
          r_cmd <= OP_WREN;
          r_faddr <= r_addr;
          r_timer <= 16'(CMD_HOLD - 1);
          r_state <= S_WREN_HOLD;
        end
        S_WREN_HOLD: if (w_tz) begin
          r_en_n <= 1'b1;
          r_timer <= 16'(GAP_CYCLES - 1);
          r_state <= S_GAP_A;
        end else r_timer <= r_timer - 16'd1;
        S_GAP_A: if (w_tz) r_state <= S_OP_ON; else r_timer <= r_timer - 16'd1;
        S_OP_ON: begin
          r_en_n <= 1'b0;
          r_cmd <= w_opcode;
          r_faddr <= r_addr;
          r_cnt <= {1'b0, r_len} + 1'b1;
          r_timer <= 16'(CMD_HOLD - 1);
          r_state <= w_is_erase ? S_OP_HOLD : S_OP_DATA;
        end
        S_OP_DATA: if (w_strobe) begin
          r_cnt <= r_cnt - 1'b1;
          r_rd_valid <= w_is_read;
          r_rd_data <= w_is_read ? fData_RD : r_rd_data;
          if (r_cnt == {{LEN_WIDTH{1'b0}}, 1'b1}) begin
            r_en_n <= 1'b1;
            r_timer <= 16'(GAP_CYCLES - 1);
            r_state <= S_GAP_B;
          end
        end
        S_OP_HOLD: if (w_tz) begin
          r_en_n <= 1'b1;
          r_timer <= 16'(GAP_CYCLES - 1);
          r_state <= S_GAP_B;
        end else r_timer <= r_timer - 16'd1;
        S_GAP_B: if (w_tz) r_state <= w_is_read ? S_FINISH : S_POLL_ON; else r_timer <= r_timer - 16'd1;
        S_POLL_ON: begin
          r_en_n <= 1'b0;
          r_cmd <= OP_RDSR;
          r_state <= S_POLL_WAIT;
        end
        S_POLL_WAIT: if (RdDataValid) begin
          r_en_n <= 1'b1;
          if (!fData_RD[0]) r_state <= S_FINISH;
          else if (r_polls == 16'(POLL_MAX - 1)) begin
            r_err <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_polls <= r_polls + 16'd1;
            r_timer <= 16'(POLL_GAP - 1);
            r_state <= S_POLL_GAP;
          end
        end
        S_POLL_GAP: if (w_tz) r_state <= S_POLL_ON; else r_timer <= r_timer - 16'd1;
        S_FINISH: begin
          r_done <= 1'b1;
          r_error <= r_err;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nano4k_flash_job_sequencer.sv
// tb_nano4k_flash_job_sequencer: randomized jobs against a flash responder and a job-level reference model
module tb_nano4k_flash_job_sequencer;
  localparam int AW = 22, LW = 9, CH = 4, GAP = 3, PG = 5, PM = 4;
  localparam logic [7:0] WREN = 8'h06, RDSR = 8'h05, PP = 8'h02, PE = 8'h81, SE = 8'h20, FREAD = 8'h0B, RDID = 8'h9F;
  logic clk = 1'b0, reset = 1'b1;
  logic jobValid = 1'b0, jobReady, wrTake, rdValid, busy, done, error, fEnable_n, RdDataValid, WrDataReady;
  logic [2:0] jobOp = '0;
  logic [AW-1:0] jobAddr = '0, fAddress;
  logic [LW-1:0] jobLen = '0;
  logic [7:0] wrData, rdData, fCommand, fData_WR, fData_RD;
  int n_chk = 0, n_pass = 0, viol = 0, job_no = 0, wip_cfg = 0;
  logic job_is_read = 1'b0, take_seen = 1'b0;
  logic [7:0] wr_base = '0;
  logic [7:0] id_tab [3];
  logic [7:0] win_cmd[$], rd_got[$], rd_sent[$], wr_got[$];
  logic [AW-1:0] win_addr[$];
  always #5 clk = ~clk;
  nano4k_flash_job_sequencer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .PAGE_BYTES(256), .CMD_HOLD(CH),
    .GAP_CYCLES(GAP), .POLL_GAP(PG), .POLL_MAX(PM)) dut (
    .interfaceClk(clk), .reset(reset), .jobValid(jobValid), .jobReady(jobReady), .jobOp(jobOp),
    .jobAddr(jobAddr), .jobLen(jobLen), .wrData(wrData), .wrTake(wrTake), .rdData(rdData),
    .rdValid(rdValid), .busy(busy), .done(done), .error(error), .fEnable_n(fEnable_n),
    .fCommand(fCommand), .fAddress(fAddress), .fData_WR(fData_WR), .fData_RD(fData_RD),
    .RdDataValid(RdDataValid), .WrDataReady(WrDataReady));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  function automatic logic [7:0] opc(input logic [2:0] op);
    return op == 3'd0 ? RDID : op == 3'd1 ? FREAD : op == 3'd2 ? PP : op == 3'd3 ? PE : op == 3'd4 ? SE : RDSR;
  endfunction
  // flash responder: random strobes inside data/status windows, WIP driven by poll count
  initial begin
    int r_job, rdsr_cnt, wr_idx, wi;
    logic prev_en, s, pp;
    logic [7:0] prev_cmd, rnd;
    r_job = 0; rdsr_cnt = 0; wr_idx = 0; wi = 0; prev_en = 1'b1; prev_cmd = '0;
    RdDataValid = 1'b0; WrDataReady = 1'b0; fData_RD = '0; wrData = '0;
    forever begin
      @(posedge clk); #1;
      if (r_job != job_no) begin r_job = job_no; rdsr_cnt = 0; wr_idx = 0; end
      else if (take_seen) wr_idx++;
      if (!prev_en && fEnable_n && prev_cmd == RDSR) rdsr_cnt++;
      if (fEnable_n) wi = 0;
      wrData = wr_base + 8'(wr_idx);
      rnd = 8'($urandom);
      if (!fEnable_n && fCommand != WREN && fCommand != PE && fCommand != SE) begin
        s = $urandom_range(0, 2) != 0;
        pp = fCommand == PP;
        WrDataReady = pp ? s : ($urandom_range(0, 3) == 0);
        RdDataValid = pp ? ($urandom_range(0, 3) == 0) : s;
        fData_RD = fCommand == RDSR ? {rnd[7:1], rdsr_cnt < wip_cfg} :
                   (fCommand == RDID && wi < 3) ? id_tab[wi] : rnd;
        if (!pp && s) begin
          if (job_is_read) rd_sent.push_back(fData_RD);
          wi++;
        end
      end else begin
        WrDataReady = 1'b0; RdDataValid = 1'b0; fData_RD = rnd;
      end
      prev_en = fEnable_n; prev_cmd = fCommand;
    end
  end
  // bus monitor: records windows and byte streams, counts protocol violations
  initial begin
    logic m_prev_en, have_prev, prev_ms, prev_rs, prev_rst;
    logic [7:0] wc;
    logic [AW-1:0] wa;
    int lo_len, hi_len;
    m_prev_en = 1'b1; have_prev = 1'b0; prev_ms = 1'b0; prev_rs = 1'b0; prev_rst = 1'b1;
    wc = '0; wa = '0; lo_len = 0; hi_len = 0;
    forever begin
      @(negedge clk);
      take_seen = wrTake;
      if (reset) have_prev = 1'b0;
      if (rdValid) begin
        rd_got.push_back(rdData);
        if (!prev_rs && !prev_rst) viol++;
      end else if (prev_rs && !prev_rst) viol++;
      if (wrTake) wr_got.push_back(fData_WR);
      if (!fEnable_n) begin
        if (m_prev_en) begin
          if (have_prev && hi_len < GAP) viol++;
          win_cmd.push_back(fCommand); win_addr.push_back(fAddress);
          wc = fCommand; wa = fAddress; lo_len = 0;
        end else if (fCommand != wc || fAddress != wa) viol++;
        lo_len++;
      end else if (!m_prev_en) begin
        if (!prev_rst) begin
          if (wc == WREN || wc == PE || wc == SE) begin if (lo_len != CH) viol++; end
          else if (!prev_ms) viol++;
          have_prev = 1'b1;
        end
        hi_len = 1;
      end else hi_len++;
      prev_ms = !fEnable_n && (wc == PP ? WrDataReady : RdDataValid);
      prev_rs = !fEnable_n && job_is_read && RdDataValid;
      prev_rst = reset; m_prev_en = fEnable_n;
    end
  end
  task automatic run_job(input logic [2:0] op, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                         input int wip, input logic [7:0] base);
    int qc, qs, qg, qw, v0, k, first_low, n, npoll, nwin;
    logic seen, err_seen, illegal, ovf, rd, traffic, exp_err;
    logic [7:0] ec;
    illegal = op > 3'd5;
    ovf = op == 3'd2 && (int'(addr[7:0]) + int'(len) + 1 > 256);
    rd = op == 3'd0 || op == 3'd1 || op == 3'd5;
    traffic = !illegal && !ovf;
    npoll = (wip + 1 < PM) ? wip + 1 : PM;
    exp_err = !traffic || (!rd && wip >= PM);
    nwin = !traffic ? 0 : rd ? 1 : 2 + npoll;
    @(negedge clk);
    chk("ready_idle", jobReady, 1);
    job_no++; job_is_read = rd; wip_cfg = wip; wr_base = base;
    qc = win_cmd.size(); qs = rd_sent.size(); qg = rd_got.size(); qw = wr_got.size(); v0 = viol;
    jobValid = 1'b1; jobOp = op; jobAddr = addr; jobLen = len;
    @(posedge clk); #1;
    jobValid = 1'b0;
    first_low = 0; seen = 1'b0; err_seen = 1'b0;
    for (k = 1; k <= 5000; k++) begin
      @(negedge clk);
      if (!fEnable_n && first_low == 0) first_low = k;
      if (done) begin
        seen = 1'b1; err_seen = error; jobValid = 1'b0;
        chk("ready_at_done", jobReady, 0);
        break;
      end
      jobValid = 1'($urandom_range(0, 1)); jobOp = 3'($urandom);
    end
    chk("done_seen", seen, 1);
    chk("error", err_seen, exp_err);
    if (traffic) chk("lat_first_cmd", first_low - 1, 2);
    else chk("lat_done", k - 1, 2);
    @(negedge clk);
    chk("ready_after_done", {jobReady, busy, done}, 3'b100);
    n = win_cmd.size() - qc;
    chk("n_windows", n, nwin);
    for (int i = 0; i < n && i < nwin; i++) begin
      ec = rd ? opc(op) : i == 0 ? WREN : i == 1 ? opc(op) : RDSR;
      chk("win_cmd", win_cmd[qc + i], ec);
    end
    if (traffic) chk("op_addr", win_addr[qc + (rd ? 0 : 1)], addr);
    if (traffic && rd) begin
      chk("rd_sent_cnt", rd_sent.size() - qs, int'(len) + 1);
      chk("rd_got_cnt", rd_got.size() - qg, int'(len) + 1);
      for (int i = 0; i <= int'(len) && qg + i < rd_got.size() && qs + i < rd_sent.size(); i++)
        chk("rd_byte", rd_got[qg + i], rd_sent[qs + i]);
    end else chk("rd_got_none", rd_got.size() - qg, 0);
    if (traffic && op == 3'd2) begin
      chk("wr_take_cnt", wr_got.size() - qw, int'(len) + 1);
      for (int i = 0; i <= int'(len) && qw + i < wr_got.size(); i++)
        chk("wr_byte", wr_got[qw + i], 8'(base + 8'(i)));
    end else chk("wr_take_none", wr_got.size() - qw, 0);
    chk("protocol", viol - v0, 0);
  endtask
  initial begin
    int qg, k, dn;
    logic [2:0] op;
    logic [LW-1:0] len;
    id_tab[0] = 8'h85; id_tab[1] = 8'h60; id_tab[2] = 8'h16;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en_n", fEnable_n, 1);
    chk("rst_cmd", fCommand, 0);
    chk("rst_addr", fAddress, 0);
    chk("rst_ready_busy", {jobReady, busy}, 2'b10);
    chk("rst_pulses", {done, error, rdValid, wrTake}, 0);
    chk("rst_rddata", rdData, 0);
    reset = 1'b0;
    run_job(3'd0, 22'h12345, 9'd2, 0, 8'd0);
    run_job(3'd2, 22'hA001, 9'd3, 2, 8'd1);
    run_job(3'd2, 22'hA0F0, 9'd16, 0, 8'd0);
    run_job(3'd4, 22'h3000, 9'd0, 100, 8'd0);
    run_job(3'd7, 22'h0, 9'd0, 0, 8'd0);
    @(negedge clk);
    job_no++; job_is_read = 1'b1;
    qg = rd_got.size();
    jobValid = 1'b1; jobOp = 3'd1; jobAddr = 22'h2AA55; jobLen = 9'd200;
    @(posedge clk); #1;
    jobValid = 1'b0;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rd_got.size() - qg >= 3) break;
    end
    chk("rst_mid_inflight", !fEnable_n, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_en_n", fEnable_n, 1);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_ready", jobReady, 1);
    reset = 1'b0;
    dn = 0;
    repeat (10) begin @(negedge clk); dn += int'(done); end
    chk("rst_mid_no_done", dn, 0);
    for (int j = 0; j < 24; j++) begin
      op = 3'($urandom_range(0, 9) > 7 ? 2 : $urandom_range(0, 7));
      len = op == 3'd2 ? 9'($urandom_range(0, 60)) : ($urandom_range(0, 7) == 0 ? 9'($urandom_range(200, 511)) : 9'($urandom_range(0, 20)));
      for (int i = 0; i < 3; i++) id_tab[i] = 8'($urandom);
      run_job(op, 22'($urandom), len, $urandom_range(0, 5), 8'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/nano4k_flash_job_sequencer.md
# nano4k_flash_job_sequencer

Parametrised job engine that sits between user logic and `nano4k_spi_flash`. It replaces hand-timed, counter-scheduled command sequences with a ready/valid job port. For each job it issues the required command chain: WREN, then the operation, then RDSR polling until the write-in-progress (WIP) bit clears. It terminates every data command on an exact byte count and streams write and read bytes to and from the user.

## Interface
Parameters:
- ADDR_WIDTH, 22, flash byte-address width
- LEN_WIDTH, 9, job length field width; byte count = jobLen+1
- PAGE_BYTES, 256, program page size, power of two
- CMD_HOLD, 64, cycles fEnable_n is held low for commands with no data phase (WREN, PE, SE)
- GAP_CYCLES, 16, minimum cycles fEnable_n stays high between commands
- POLL_GAP, 256, idle cycles between RDSR polls
- POLL_MAX, 65535, polls allowed before timeout error
- OP_WREN 8'h06, OP_RDSR 8'h05, OP_PP 8'h02, OP_PE 8'h81, OP_SE 8'h20, OP_FREAD 8'h0B, OP_RDID 8'h9F; command opcodes

Ports:
- interfaceClk  in  1  sole clock; same clock as the controller's interfaceClk
- reset  in  1  synchronous, active-high
- jobValid  in  1  job request
- jobReady  out  1  high only in IDLE
- jobOp  in  3  0 READ_ID, 1 READ, 2 PROGRAM, 3 PAGE_ERASE, 4 SECTOR_ERASE, 5 READ_STATUS; 6–7 illegal
- jobAddr  in  ADDR_WIDTH  start address
- jobLen  in  LEN_WIDTH  data bytes minus one; ignored for erases
- wrData  in  8  next program byte; passed through to fData_WR
- wrTake  out  1  one-cycle pulse: the controller consumed wrData; upstream advances
- rdData  out  8  registered read byte
- rdValid  out  1  one-cycle pulse per read byte
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle pulse at job end
- error  out  1  valid with done; 1 = illegal op, page overflow, or poll timeout
- fEnable_n  out  1  controller interfaceEnable_n
- fCommand  out  8  controller fCommand
- fAddress  out  ADDR_WIDTH  controller fAddress
- fData_WR  out  8  controller fData_WR
- fData_RD  in  8  controller fData_RD
- RdDataValid  in  1  controller read strobe
- WrDataReady  in  1  controller write strobe

## Operation
- States: IDLE, CHECK, WREN_ON, WREN_HOLD, GAP_A, OP_ON, OP_DATA, OP_HOLD, GAP_B, POLL_ON, POLL_WAIT, POLL_GAP, FINISH.
- Accept: jobValid && jobReady. On accept, latch op, address and length into registers, then go to CHECK.
- CHECK covers the illegal-op and overflow checks, and routing:
  - Illegal op: FINISH with error=1.
  - PROGRAM overflow: if (jobAddr mod PAGE_BYTES) + jobLen + 1 > PAGE_BYTES, go to FINISH with error=1. No flash traffic is issued.
  - Routing: READ_ID, READ and READ_STATUS go to OP_ON. PROGRAM, PAGE_ERASE and SECTOR_ERASE go to WREN_ON.
- WREN: fCommand=OP_WREN and fEnable_n=0 for CMD_HOLD cycles, then fEnable_n=1 and wait GAP_CYCLES in GAP_A, then OP_ON.
- OP_ON drives the opcode and fAddress and sets fEnable_n=0.
  - Data ops enter OP_DATA and load the byte counter with jobLen+1.
  - Erase ops enter OP_HOLD, which lasts CMD_HOLD cycles.
- OP_DATA:
  - Each RdDataValid (read ops) or WrDataReady (PROGRAM) decrements the counter.
  - Read ops: each RdDataValid captures fData_RD into rdData and pulses rdValid.
  - PROGRAM: each WrDataReady pulses wrTake combinationally.
  - When the strobe that brings the counter to 0 is seen, fEnable_n goes high on the next edge.
  - Strobes of the non-matching type are ignored.
- After the data phase or OP_HOLD, enter GAP_B for GAP_CYCLES.
  - Read ops then go to FINISH.
  - Write/erase ops then go to POLL_ON.
- Polling:
  - POLL_ON issues OP_RDSR and moves to POLL_WAIT.
  - On the first RdDataValid, set fEnable_n=1. Polled status bytes do not pulse rdValid.
  - If bit0 (WIP)=0, go to FINISH.
  - Otherwise increment the poll counter. At POLL_MAX, go to FINISH with error=1; else wait POLL_GAP cycles, then POLL_ON.
- FINISH: pulse done, drive error, return to IDLE.

## Timing
- Reset values: state IDLE, fEnable_n=1, fCommand=0, fAddress=0, jobReady=1, busy=0, done=0, error=0, rdValid=0, wrTake=0, rdData=0.
- Reset asserted mid-job: on the next edge, fEnable_n=1, state IDLE, and done is not pulsed.
- Accept-to-first-command latency:
  - Reads: fEnable_n falls 2 cycles after the accept edge.
  - Writes/erases: WREN fEnable_n falls 2 cycles after the accept edge.
- Illegal/overflow: done=1 and error=1 two cycles after accept.
- fEnable_n rises exactly one cycle after the last counted strobe.
- rdValid follows RdDataValid by one cycle.
- fCommand and fAddress are stable throughout each fEnable_n-low window.
- fEnable_n-high windows between commands are never shorter than GAP_CYCLES.
- jobValid while busy is not accepted; jobReady=0.
- done precedes the next jobReady=1 by one cycle.

## Test plan
- READ_ID, jobLen=2, model returns 8'h85,8'h60,8'h16 → one fEnable_n window with fCommand=8'h9F; rdData sequence 85,60,16 with three rdValid pulses; done, error=0.
- PROGRAM at 22'hA001, jobLen=3, wrData stream 1,2,3,4; WIP=1 for two polls then 0 → sequence WREN, PP (exactly 4 wrTake pulses, fEnable_n high one cycle after the 4th strobe), then 3 RDSR windows; done, error=0.
- PROGRAM at 22'hA0F0, jobLen=16 (17 bytes, crosses page) → no fEnable_n activity; done and error=1 two cycles after accept.
- SECTOR_ERASE with WIP stuck at 1 and POLL_MAX=4 → 4 RDSR windows, then done with error=1.
- jobOp=7 → error done; reset asserted mid FREAD data phase → fEnable_n=1 next edge, no done, jobReady=1.
